// File: rtl/axi_arbiter_w.sv
// axi_arbiter_w: round-robin write-channel arbiter for a 4-master AXI4 interconnect.
// Define AXI_WARB_TIMEOUT_EN to add the stall watchdog and the wr_timeout port.
module axi_arbiter_w #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int RST_PTR        = 0
) (
  input  logic       ACLK,
  input  logic       ARESET,
  input  logic       m0_AWVALID,
  input  logic       m1_AWVALID,
  input  logic       m2_AWVALID,
  input  logic       m3_AWVALID,
  input  logic       s_AWVALID,
  input  logic       s_WVALID,
  input  logic       s_WLAST,
  input  logic       s_BREADY,
  input  logic       m_AWREADY,
  input  logic       m_WREADY,
  input  logic       m_BVALID,
  output logic       m0_wgrnt,
  output logic       m1_wgrnt,
  output logic       m2_wgrnt,
  output logic       m3_wgrnt,
  output logic       wr_busy,
  output logic [1:0] wr_owner
`ifdef AXI_WARB_TIMEOUT_EN
  ,
  output logic       wr_timeout
`endif
);
  typedef enum logic [1:0] {IDLE, DATA, RESP} state_t;
  state_t     r_state, w_state_nxt;
  logic [1:0] r_ptr, w_ptr_nxt, r_owner, w_owner_nxt, w_sel;
  logic [3:0] r_grnt, w_grnt_nxt, w_req;
  logic       r_busy, r_aw_done, r_w_done, w_aw_nxt, w_w_nxt;
  logic       w_aw_hs, w_wl_hs, w_b_hs, w_release, w_force;
  assign w_req   = {m3_AWVALID, m2_AWVALID, m1_AWVALID, m0_AWVALID};
  assign w_aw_hs = s_AWVALID & m_AWREADY;
  assign w_wl_hs = s_WVALID & m_WREADY & s_WLAST;
  assign w_b_hs  = m_BVALID & s_BREADY;
  assign w_release = ((r_state == RESP) & w_b_hs) | w_force;
  // Lowest offset from the pointer wins, so scan offsets from high to low.
  always_comb begin
    w_sel = r_ptr;
    for (int k = 3; k >= 0; k--)
      if (w_req[r_ptr + 2'(k)]) w_sel = r_ptr + 2'(k);
  end
  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_owner_nxt = r_owner;
    w_grnt_nxt  = r_grnt;
    w_aw_nxt    = r_aw_done;
    w_w_nxt     = r_w_done;
    case (r_state)
      IDLE: if (|w_req) begin
        w_grnt_nxt  = 4'b0001 << w_sel;
        w_owner_nxt = w_sel;
        w_state_nxt = DATA;
      end
      DATA: begin
        w_aw_nxt = r_aw_done | w_aw_hs;
        w_w_nxt  = r_w_done | w_wl_hs;
        w_state_nxt = (w_aw_nxt & w_w_nxt) ? RESP : DATA;
      end
      RESP: w_state_nxt = RESP;
      default: w_state_nxt = IDLE;
    endcase
    if (w_release) begin
      w_grnt_nxt  = 4'b0000;
      w_ptr_nxt   = r_owner + 2'd1;
      w_aw_nxt    = 1'b0;
      w_w_nxt     = 1'b0;
      w_state_nxt = IDLE;
    end
  end
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_state   <= IDLE;
      r_ptr     <= 2'(RST_PTR);
      r_owner   <= 2'd0;
      r_grnt    <= 4'b0000;
      r_busy    <= 1'b0;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_ptr     <= w_ptr_nxt;
      r_owner   <= w_owner_nxt;
      r_grnt    <= w_grnt_nxt;
      r_busy    <= |w_grnt_nxt;
      r_aw_done <= w_aw_nxt;
      r_w_done  <= w_w_nxt;
    end
  end
`ifdef AXI_WARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CW-1:0] LIM = CW'(TIMEOUT_CYCLES - 1);
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic          r_timeout;
  assign w_force = (r_state != IDLE) & (r_cnt == LIM);
  // Any sign of progress or any state change restarts the stall count.
  assign w_cnt_nxt = ((w_state_nxt == IDLE) | (w_state_nxt != r_state) | w_aw_hs |
                      (s_WVALID & m_WREADY) | w_b_hs) ? '0 : r_cnt + 1'b1;
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_cnt     <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_cnt     <= w_cnt_nxt;
      r_timeout <= (w_state_nxt != IDLE) & (w_cnt_nxt == LIM);
    end
  end
  assign wr_timeout = r_timeout;
`else
  logic w_unused_timeout;
  assign w_unused_timeout = ^TIMEOUT_CYCLES;
  assign w_force = 1'b0;
`endif
  assign {m3_wgrnt, m2_wgrnt, m1_wgrnt, m0_wgrnt} = r_grnt;
  assign wr_busy  = r_busy;
  assign wr_owner = r_owner;
endmodule

// File: tb/tb_axi_arbiter_w.sv
// tb_axi_arbiter_w: directed scenarios plus randomized traffic against a transaction-level model.
module tb_axi_arbiter_w;
  logic       ACLK = 1'b0, ARESET = 1'b1;
  logic [3:0] req = 4'b0, gnt;
  logic       s_awv = 0, m_awr = 0, s_wv = 0, m_wr = 0, s_wl = 0, m_bv = 0, s_br = 0;
  logic       wr_busy;
  logic [1:0] wr_owner;
  logic [6:0] e;
  int n_cmp = 0, n_err = 0;
  int mo = -1, mptr = 0, mlast = 0;
  bit maw = 0, mw = 0, mresp = 0;
  always #5 ACLK = ~ACLK;
  axi_arbiter_w dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .m0_AWVALID(req[0]), .m1_AWVALID(req[1]), .m2_AWVALID(req[2]), .m3_AWVALID(req[3]),
    .s_AWVALID(s_awv), .s_WVALID(s_wv), .s_WLAST(s_wl), .s_BREADY(s_br),
    .m_AWREADY(m_awr), .m_WREADY(m_wr), .m_BVALID(m_bv),
    .m0_wgrnt(gnt[0]), .m1_wgrnt(gnt[1]), .m2_wgrnt(gnt[2]), .m3_wgrnt(gnt[3]),
    .wr_busy(wr_busy), .wr_owner(wr_owner)
  );
  wire [6:0] obs = {gnt, wr_busy, wr_owner};
  // Transaction view: an owner holds the path until AW and last W are both seen, then B.
  task automatic model_step();
    if (ARESET) begin
      mo = -1; mptr = 0; mlast = 0; maw = 0; mw = 0; mresp = 0;
    end else if (mo < 0) begin
      for (int k = 0; k < 4; k++)
        if (mo < 0 && req[(mptr + k) % 4]) begin
          mo = (mptr + k) % 4; mlast = mo; maw = 0; mw = 0; mresp = 0;
        end
    end else if (!mresp) begin
      maw = maw | (s_awv & m_awr);
      mw  = mw | (s_wv & m_wr & s_wl);
      mresp = maw & mw;
    end else if (m_bv & s_br) begin
      mptr = (mo + 1) % 4; mo = -1;
    end
  endtask
  task automatic tick();
    @(posedge ACLK);
    model_step();
    #1;
  endtask
  task automatic set_hs(input logic [6:0] v);
    {s_awv, m_awr, s_wv, m_wr, s_wl, m_bv, s_br} = v;
  endtask
  task automatic do_reset();
    ARESET = 1'b1; req = 4'b0; set_hs(7'b0);
    tick();
    ARESET = 1'b0;
  endtask
  task automatic test_reset();
    do_reset();
    n_cmp++;
    if (obs !== 7'b0000_0_00) begin n_err++; $display("FAIL reset obs=%b exp=%b", obs, 7'b0000_0_00); end
  endtask
  task automatic test_first_grant();
    repeat (4) tick();
    req = 4'b0100;
    n_cmp++;
    if (obs !== 7'b0000_0_00) begin n_err++; $display("FAIL pre_grant obs=%b exp=%b", obs, 7'b0000_0_00); end
    tick();
    n_cmp++;
    if (obs !== 7'b0100_1_10) begin n_err++; $display("FAIL first_grant obs=%b exp=%b", obs, 7'b0100_1_10); end
  endtask
  task automatic test_round_robin();
    do_reset();
    req = 4'hF;
    tick();
    for (int i = 0; i < 5; i++) begin
      e = {4'(1 << (i % 4)), 1'b1, 2'(i % 4)};
      n_cmp++;
      if (obs !== e) begin n_err++; $display("FAIL rr_grant%0d obs=%b exp=%b", i, obs, e); end
      set_hs(7'b1111100); tick();
      set_hs(7'b0000011); tick();
      n_cmp++;
      if (gnt !== 4'b0 || wr_busy !== 1'b0) begin n_err++; $display("FAIL rr_idle%0d gnt=%b busy=%b exp 0", i, gnt, wr_busy); end
      set_hs(7'b0); tick();
    end
  endtask
  task automatic test_w_before_aw();
    do_reset();
    req = 4'b0010;
    tick();
    req = 4'b0000;
    set_hs(7'b0011100); tick();
    set_hs(7'b0); tick();
    set_hs(7'b0000011); tick();
    n_cmp++;
    if (obs !== 7'b0010_1_01) begin n_err++; $display("FAIL b_in_data obs=%b exp=%b", obs, 7'b0010_1_01); end
    set_hs(7'b1100000); tick();
    n_cmp++;
    if (obs !== 7'b0010_1_01) begin n_err++; $display("FAIL resp_hold obs=%b exp=%b", obs, 7'b0010_1_01); end
    req = 4'b0101;
    set_hs(7'b0000011); tick();
    n_cmp++;
    if (obs !== 7'b0000_0_01) begin n_err++; $display("FAIL w_first_release obs=%b exp=%b", obs, 7'b0000_0_01); end
    set_hs(7'b0); tick();
    n_cmp++;
    if (obs !== 7'b0100_1_10) begin n_err++; $display("FAIL ptr_after_m1 obs=%b exp=%b", obs, 7'b0100_1_10); end
  endtask
  task automatic test_multibeat();
    do_reset();
    req = 4'b1001;
    tick();
    req = 4'b1000;
    set_hs(7'b1111000); tick();
    for (int b = 1; b < 4; b++) begin
      n_cmp++;
      if (obs !== 7'b0001_1_00) begin n_err++; $display("FAIL burst_hold%0d obs=%b exp=%b", b, obs, 7'b0001_1_00); end
      set_hs(b == 3 ? 7'b0011100 : 7'b0011000); tick();
    end
    set_hs(7'b0);
    tick();
    n_cmp++;
    if (obs !== 7'b0001_1_00) begin n_err++; $display("FAIL burst_resp obs=%b exp=%b", obs, 7'b0001_1_00); end
    set_hs(7'b0000011); tick();
    set_hs(7'b0); tick();
    n_cmp++;
    if (obs !== 7'b1000_1_11) begin n_err++; $display("FAIL burst_next obs=%b exp=%b", obs, 7'b1000_1_11); end
  endtask
  task automatic test_reset_mid();
    do_reset();
    req = 4'b0100;
    tick();
    set_hs(7'b1111100); tick();
    set_hs(7'b0000011); tick();
    set_hs(7'b0); tick();
    set_hs(7'b1111100); tick();
    set_hs(7'b0);
    ARESET = 1'b1; tick(); ARESET = 1'b0;
    req = 4'b1100;
    n_cmp++;
    if (obs !== 7'b0000_0_00) begin n_err++; $display("FAIL mid_reset obs=%b exp=%b", obs, 7'b0000_0_00); end
    tick();
    n_cmp++;
    if (obs !== 7'b0100_1_10) begin n_err++; $display("FAIL reset_ptr obs=%b exp=%b", obs, 7'b0100_1_10); end
  endtask
  task automatic test_random();
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      req = 4'($urandom);
      set_hs(7'($urandom));
      ARESET = ($urandom_range(0, 99) == 0);
      tick();
      e = {(mo < 0) ? 4'b0 : 4'(1 << mo), mo >= 0, 2'(mlast)};
      n_cmp++;
      if (obs !== e) begin n_err++; $display("FAIL random c=%0d obs=%b exp=%b", c, obs, e); end
      n_cmp++;
      if ($countones(gnt) > 1) begin n_err++; $display("FAIL onehot c=%0d gnt=%b exp at most one bit", c, gnt); end
    end
    ARESET = 1'b0;
  endtask
  initial begin
    test_reset();
    test_first_grant();
    test_round_robin();
    test_w_before_aw();
    test_multibeat();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
